// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package ifetch_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid.sv
// Skid entry that parks an unaccepted ROM response, plus the decode-facing output mux.
module fetch_skid
  import ifetch_pkg::*;
(
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic              resp_v,
  input  logic [31:0]       resp_pc,
  input  logic [INST_W-1:0] rom_rdata,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  output logic              inst_valid
);

  logic         hold_v;
  fetch_entry_t hold_q;

  // The ROM word is only on the bus for one cycle, so a stalled response must be parked here.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      hold_v <= 1'b0;
      hold_q <= '0;
    end else if (redirect) begin
      hold_v <= 1'b0;
    end else if (stall) begin
      if (resp_v && !hold_v) begin
        hold_q <= '{inst: rom_rdata, pc: resp_pc};
        hold_v <= 1'b1;
      end
    end else begin
      hold_v <= 1'b0;
    end
  end

  always_comb begin
    inst_valid = (hold_v || resp_v) && !redirect;
    inst_pc    = hold_v ? hold_q.pc : resp_pc;
    inst       = NOP_INST;
    if (inst_valid) inst = hold_v ? hold_q.inst : rom_rdata;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC sequencing against a one-cycle-latency code ROM.
// Optional IFETCH_PERF_CNT_EN adds a consumed-instruction counter port fetch_count.
module inst_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              m_clock,
  input  logic              p_reset,
  output logic [31:0]       rom_addr,
  input  logic [INST_W-1:0] rom_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  output logic              inst_valid
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  logic [31:0] pc_q;
  logic [31:0] resp_pc;
  logic        resp_v;

  assign rom_addr = {pc_q[31:2], 2'b00};

  // On stall the same address is reissued so the ROM response after release is the right one.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      pc_q    <= RESET_PC;
      resp_v  <= 1'b0;
      resp_pc <= '0;
    end else if (redirect) begin
      pc_q   <= redirect_pc & 32'hFFFF_FFFC;
      resp_v <= 1'b0;
    end else if (stall) begin
      resp_v <= 1'b0;
    end else begin
      pc_q    <= pc_q + 32'd4;
      resp_v  <= 1'b1;
      resp_pc <= pc_q;
    end
  end

  fetch_skid u_skid (
    .m_clock    (m_clock),
    .p_reset    (p_reset),
    .stall      (stall),
    .redirect   (redirect),
    .resp_v     (resp_v),
    .resp_pc    (resp_pc),
    .rom_rdata  (rom_rdata),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid)
  );

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) fetch_count <= '0;
    else if (inst_valid && !stall) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a one-cycle-latency ROM model.
module tb_inst_fetch;
  import ifetch_pkg::*;

  logic        m_clock;
  logic        p_reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .m_clock     (m_clock),
    .p_reset     (p_reset),
    .rom_addr    (rom_addr),
    .rom_rdata   (rom_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  function automatic logic [31:0] rom_val(input logic [31:0] a);
    return (a * 32'd7) ^ 32'h0BAD_F00D;
  endfunction

  always @(posedge m_clock) rom_rdata <= rom_val(rom_addr);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic tick();
    @(posedge m_clock);
    #1;
  endtask

  task automatic checkInst(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, 32'(inst_valid), 32'd1);
    checkOutput({tag, "_pc"}, inst_pc, pc);
    checkOutput({tag, "_inst"}, inst, rom_val(pc));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [13:0] stall_pat;
    stall_pat = 14'h088C;

    p_reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (2) tick();
    checkOutput("rst_addr", rom_addr, 32'h0);
    checkOutput("rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_inst", inst, NOP_INST);
`ifdef IFETCH_PERF_CNT_EN
    checkOutput("rst_count", fetch_count, 32'd0);
`endif

    // Release reset between edges; the first edge issues the fetch of RESET_PC.
    #2 p_reset = 1'b1;
    #1;
    checkOutput("fill_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkInst($sformatf("run%0d", i), 32'(i * 4));
    end

    // Stall for three cycles with pc 8 on the outputs.
    applyStimulus(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checkInst($sformatf("stall%0d", i), 32'h8);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkInst("release", 32'h8);
    tick();
    checkInst("after_rel", 32'hC);
    tick();
    checkInst("after_rel2", 32'h10);

    // Redirect beats stall and drops the low address bits.
    applyStimulus(1'b1, 1'b1, 32'h0000_0103);
    checkOutput("redir_valid", 32'(inst_valid), 32'd0);
    checkOutput("redir_inst", inst, NOP_INST);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("redir_fill_valid", 32'(inst_valid), 32'd0);
    checkOutput("redir_addr", rom_addr, 32'h0000_0100);
    tick();
    checkInst("redir_tgt", 32'h0000_0100);

    // PC wrap at the top of the address space.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
    checkOutput("wrap_redir_valid", 32'(inst_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("wrap_fill_valid", 32'(inst_valid), 32'd0);
    checkOutput("wrap_addr", rom_addr, 32'hFFFF_FFF8);
    tick();
    checkInst("wrap0", 32'hFFFF_FFF8);
    tick();
    checkInst("wrap1", 32'hFFFF_FFFC);
    tick();
    checkInst("wrap2", 32'h0000_0000);
    tick();
    checkInst("wrap3", 32'h0000_0004);

    // Reset asserted while an instruction is parked in the skid entry.
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    checkInst("hold_pre_rst", 32'h4);
    p_reset = 1'b0;
    #1;
    checkOutput("hold_rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("hold_rst_inst", inst, NOP_INST);
    checkOutput("hold_rst_addr", rom_addr, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    checkOutput("hold_rst_count", fetch_count, 32'd0);
`endif
    applyStimulus(1'b0, 1'b0, 32'h0);
    p_reset = 1'b1;
    #1;
    checkOutput("restart_fill", 32'(inst_valid), 32'd0);
    tick();
    checkInst("restart0", 32'h0);

    // Ten consumptions interleaved with four stall cycles.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(stall_pat[i], 1'b0, 32'h0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkInst("perf_next", 32'h28);
`ifdef IFETCH_PERF_CNT_EN
    checkOutput("perf_count", fetch_count, 32'd10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port m_clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port p_reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rom_addr, output, 32 bits: byte address to the code ROM wrapper, which samples it at each m_clock edge and returns data one cycle later.
REQ-005 SHALL have port rom_rdata, input, 32 bits: ROM word for the address sampled at the previous edge.
REQ-006 SHALL have port stall, input, 1 bit: decode cannot accept an instruction this cycle.
REQ-007 SHALL have port redirect, input, 1 bit: branch/jump/trap flush request.
REQ-008 SHALL have port redirect_pc, input, 32 bits: new fetch target; bits [1:0] are ignored.
REQ-009 SHALL have port inst, output, 32 bits: instruction to decode.
REQ-010 SHALL have port inst_pc, output, 32 bits: address of inst.
REQ-011 SHALL have port inst_valid, output, 1 bit: inst/inst_pc are meaningful.

Function
REQ-012 SHALL hold state in pc_q (address issued this cycle), resp_v/resp_pc (request in flight), and hold_v/hold_inst/hold_pc (skid entry).
REQ-013 SHALL drive rom_addr = {pc_q[31:2], 2'b00} combinationally.
REQ-014 SHALL use three states: FILL (resp_v=0, hold_v=0), RUN (resp_v=1), and HOLD (hold_v=1); resp_v and hold_v are never both 1.
REQ-015 SHALL select outputs with hold_v=1 giving inst=hold_inst, inst_pc=hold_pc, inst_valid=1; otherwise inst=rom_rdata, inst_pc=resp_pc, inst_valid=resp_v.
REQ-016 SHALL force inst_valid=0 in any cycle with redirect=1, and SHALL drive inst=32'h0000_0013 (NOP) whenever inst_valid=0.
REQ-017 SHALL count an instruction as consumed only when inst_valid=1 and stall=0.
REQ-018 SHALL, on redirect=1 (priority over stall), update pc_q<=redirect_pc with bits [1:0] cleared, resp_v<=0, and hold_v<=0.
REQ-019 SHALL, on stall=1 without redirect, keep pc_q unchanged and set resp_v<=0; if resp_v=1 and hold_v=0, it SHALL capture hold_inst<=rom_rdata, hold_pc<=resp_pc, and hold_v<=1.
REQ-020 SHALL, on stall=0 without redirect, update pc_q<=pc_q+4 (modulo 2^32, wrapping FFFF_FFFC->0000_0000), resp_v<=1, resp_pc<=pc_q, and hold_v<=0.
REQ-021 SHALL sustain one instruction per cycle with no stall and no redirect; fetch-to-valid latency SHALL be one cycle.
REQ-022 SHALL lose and duplicate no instruction across any stall length, including stall released while in HOLD.

Reset
REQ-023 SHALL, while p_reset=0, asynchronously set pc_q=RESET_PC, resp_v=0, hold_v=0, resp_pc=0, and hold_pc=0, giving rom_addr=RESET_PC, inst_valid=0, and inst=NOP.
REQ-024 SHALL present the first valid instruction (inst_pc=RESET_PC) in the second cycle after p_reset deasserts, given stall=0; reset mid-stream discards all in-flight and held data.

Configuration
REQ-025 SHALL, with IFETCH_PERF_CNT_EN defined, add output fetch_count [31:0], reset to 0, incremented by 1 per consumed instruction (REQ-017) and wrapping at 2^32.
REQ-026 SHALL, without IFETCH_PERF_CNT_EN, have no fetch_count port and no counter logic; all other behaviour SHALL be identical.

Structure
REQ-027 SHALL place INST_W=32, the NOP encoding 32'h0000_0013, and the default RESET_PC in shared package ifetch_pkg.
REQ-028 SHALL implement the hold register and output mux as sub-module fetch_skid, with the PC and next-PC logic in inst_fetch.

Verification
REQ-029 SHALL test reset release with RESET_PC=0 and stall=0: inst_pc sequence 0,4,8,... from cycle 2, inst_valid continuously 1, inst equal to ROM contents.
REQ-030 SHALL test stall held 3 cycles while inst_pc=8 is valid: 8 held on outputs throughout, then 8 consumed on release followed by C the next cycle with no gap.
REQ-031 SHALL test redirect=1 with redirect_pc=0x103 in the same cycle as stall=1: inst_valid=0 that cycle, next cycle inst_valid=0, rom_addr=0x100, then inst_pc=0x100.
REQ-032 SHALL test the pc_q wrap with the redirect target at FFFF_FFF8: consumed inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-033 SHALL test p_reset asserted during HOLD: inst_valid=0 immediately (asynchronously), and the sequence restarts at RESET_PC.
REQ-034 SHALL test with IFETCH_PERF_CNT_EN: 10 consumptions interleaved with 4 stall cycles give fetch_count=10.
